lsu_writeback: RTL and testbench
================================

Name: lsu_writeback

Overview:
- Multi-cycle load/store unit sitting between execute and data memory.
- Accepts one load/store request at a time, runs a valid/ready handshake to data memory, and aligns and sign/zero-extends load data.
- Drives the register file write port (wb_en, wb_rd, wb_data), so it is the writer that feeds the register file.
- Stores produce byte strobes and no writeback.

Parameters:
- XLEN, 32, data/address width; must equal word_t width.
- TIMEOUT, 255, maximum cycles waiting for mem_rvalid before a fault; valid range 1..1023.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request from execute
- req_ready  out  1  high only in IDLE
- req_is_store  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data (rs2)
- req_rd  in  5  destination register (reg_addr_t)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  1=write
- mem_addr  out  XLEN  word-aligned address, bits [1:0] always 0
- mem_wdata  out  XLEN  lane-replicated store data
- mem_wstrb  out  4  byte enables; 0000 on reads
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read word
- wb_en  out  1  register write-enable pulse
- wb_rd  out  5  write register
- wb_data  out  XLEN  write data
- done  out  1  1-cycle pulse when a request completes without fault
- fault  out  1  1-cycle pulse when a request is aborted
- fault_cause  out  2  01 misaligned, 10 timeout, 11 illegal funct3; valid with fault

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, timeout counter 0. Every output is 0 except req_ready=1.
- Request capture: a handshake occurs when req_valid && req_ready. Request fields are captured into registers. The next state is CHECK.
- CHECK (1 cycle) faults in priority order; any fault pulses fault and fault_cause in the next cycle, returns to IDLE, and makes no memory access and no writeback:
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010 → fault_cause 11.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠00 → fault_cause 01.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1. mem_we, mem_addr, mem_wdata and mem_wstrb are held stable until mem_req_ready.
  - Store on handshake: done pulses next cycle, then IDLE.
  - Load on handshake: go to WAIT and clear the counter.
- Store lanes:
  - SB: mem_wstrb = 0001 << addr[1:0]; mem_wdata = byte ×4.
  - SH: mem_wstrb = 0011 (addr[1]=0) or 1100; mem_wdata = half ×2.
  - SW: mem_wstrb = 1111.
- WAIT:
  - Counter increments each cycle without mem_rvalid. Reaching TIMEOUT → fault with cause 10, then IDLE, no writeback.
  - On mem_rvalid: select byte at addr[1:0] or half at addr[1]; sign-extend (B, H) or zero-extend (BU, HU); W passes through.
  - The next cycle pulses wb_en and done, with wb_rd and wb_data valid for that cycle, then IDLE.
  - If rd=0, wb_en stays 0 but done still pulses.
  - mem_rvalid in the same cycle the counter hits TIMEOUT: the data wins and there is no fault.
- mem_rvalid outside WAIT is ignored, including stale responses after reset.
- wb_rd and wb_data hold their last values when wb_en=0. wb_en is never high for more than 1 cycle.
- Latency with zero-wait memory (mem_req_ready=1, rvalid the cycle after the handshake):
  - Load: accept at cycle 0, wb_en at cycle 4.
  - Store: done at cycle 3.
- Reset asserted mid-operation aborts immediately. No done/fault/wb pulse is produced afterwards.

Decomposition:
- types_pkg additions:
  - mem_size_t enum (B/H/W/BU/HU, encoded as funct3)
  - lsu_state_t enum (IDLE, CHECK, REQ, WAIT, RESP)
  - fault_cause_t (2-bit)
  - constant WSTRB_W = 4
- Reuses word_t and reg_addr_t.
- One sub-module, load_align: combinational selection plus sign/zero-extension of mem_rdata given addr[1:0] and funct3. It is shared with a future store-data formatter test.

Test Plan:
- LB at addr 0x1003, mem_rdata=0x80FF_1234, rd=5 → mem_addr=0x1000, wstrb=0000; wb_en pulse with wb_rd=5, wb_data=0xFFFF_FF80.
- LHU at 0x2002, mem_rdata=0xBEEF_0000 → wb_data=0x0000_BEEF. Same access as LH → 0xFFFF_BEEF.
- SH at 0x3002, wdata=0x1234_ABCD, mem_req_ready low for 3 cycles → request held stable, then wstrb=1100, mem_wdata=0xABCD_ABCD; done once; no wb_en.
- LW at 0x4001 → fault with cause 01 two cycles after accept; mem_req_valid never asserted. funct3=011 load → cause 11.
- LW with mem_rvalid withheld and TIMEOUT=8 → fault with cause 10 after 8 WAIT cycles. A late rvalid afterwards is ignored; next request accepted normally.
- LW to rd=0 → done pulses, wb_en stays 0. rst_n dropped in WAIT → all pulses 0 and req_ready=1 immediately.

Source files
------------

// File: rtl/lsu_writeback_pkg.sv
// Shared types and helpers for the load/store writeback unit.
// Contents:
//   word_t / reg_addr_t   data word and register-index types
//   mem_size_t            access size/sign, encoded as RISC-V funct3
//   lsu_state_t           control FSM states
//   fault_cause_t         2-bit fault code reported alongside a fault pulse
//   helper functions      funct3 legality, alignment, store strobes and lanes
package lsu_writeback_pkg;

    localparam int WORD_W  = 32;
    localparam int WSTRB_W = 4;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [4:0]         reg_addr_t;
    typedef logic [WSTRB_W-1:0] wstrb_t;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_t;

    typedef logic [1:0] fault_cause_t;

    localparam fault_cause_t FC_NONE     = 2'b00;
    localparam fault_cause_t FC_MISALIGN = 2'b01;
    localparam fault_cause_t FC_TIMEOUT  = 2'b10;
    localparam fault_cause_t FC_ILLEGAL  = 2'b11;

    // Stores only exist in the signed encodings B/H/W; loads reject 011/110/111.
    function automatic logic funct3_illegal(input logic is_store, input logic [2:0] funct3);
        logic bad;
        if (is_store) begin
            bad = (funct3 != MEM_B) && (funct3 != MEM_H) && (funct3 != MEM_W);
        end else begin
            bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        return bad;
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            MEM_H, MEM_HU: bad = addr_lo[0];
            MEM_W:         bad = (addr_lo != 2'b00);
            default:       bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic wstrb_t store_strobe(input logic [2:0] funct3, input logic [1:0] addr_lo);
        wstrb_t strb;
        case (funct3)
            MEM_B:   strb = 4'b0001 << addr_lo;
            MEM_H:   strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            MEM_W:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Replicate the store data across every lane so the strobe alone selects the target bytes.
    function automatic word_t store_lanes(input logic [2:0] funct3, input word_t wdata);
        word_t lanes;
        case (funct3)
            MEM_B:   lanes = {4{wdata[7:0]}};
            MEM_H:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_writeback_load_align.sv
// Load data alignment: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it according to funct3. Purely combinational.
// Ports:
//   rdata_i    raw word returned by data memory
//   addr_lo_i  byte offset within the word (addr[1:0])
//   funct3_i   access size/sign (B/H/W/BU/HU)
//   data_o     register-ready value
module lsu_writeback_load_align
    import lsu_writeback_pkg::*;
(
    input  word_t      rdata_i,
    input  logic [1:0] addr_lo_i,
    input  logic [2:0] funct3_i,
    output word_t      data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by size/sign extension.
    always_comb begin
        case (addr_lo_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            2'b11:   byte_s = rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase

        if (addr_lo_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end

        case (funct3_i)
            MEM_B:   data_o = {{24{byte_s[7]}}, byte_s};
            MEM_BU:  data_o = {24'h000000, byte_s};
            MEM_H:   data_o = {{16{half_s[15]}}, half_s};
            MEM_HU:  data_o = {16'h0000, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_writeback.sv
// Multi-cycle load/store unit between execute and data memory. Takes one
// request at a time, checks funct3 legality and alignment, performs a
// valid/ready memory request, aligns load data and writes it back to the
// register file. All outputs are registered.
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   req_*                           request from execute (req_ready high only when idle)
//   mem_req_valid/ready, mem_we,
//   mem_addr, mem_wdata, mem_wstrb  memory request channel (word-aligned address)
//   mem_rvalid, mem_rdata           memory read response
//   wb_en, wb_rd, wb_data           register file write port
//   done, fault, fault_cause        completion / abort pulses
module lsu_writeback
    import lsu_writeback_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            done,
    output logic            fault,
    output logic [1:0]      fault_cause
);

    localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

    lsu_state_t   state_q, state_d;
    logic         store_q, store_d;
    logic [2:0]   funct3_q, funct3_d;
    word_t        addr_q, addr_d;
    word_t        wdata_q, wdata_d;
    reg_addr_t    rd_q, rd_d;
    logic [9:0]   cnt_q, cnt_d;
    logic         req_ready_q, req_ready_d;
    logic         mem_req_valid_q, mem_req_valid_d;
    logic         mem_we_q, mem_we_d;
    word_t        mem_addr_q, mem_addr_d;
    word_t        mem_wdata_q, mem_wdata_d;
    wstrb_t       mem_wstrb_q, mem_wstrb_d;
    logic         wb_en_q, wb_en_d;
    reg_addr_t    wb_rd_q, wb_rd_d;
    word_t        wb_data_q, wb_data_d;
    logic         done_q, done_d;
    logic         fault_q, fault_d;
    fault_cause_t fault_cause_q, fault_cause_d;
    word_t        load_data_s;

    lsu_writeback_load_align u_load_align (
        .rdata_i   (mem_rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .data_o    (load_data_s)
    );

    // Next-state and registered-output computation for the control FSM.
    always_comb begin
        state_d       = state_q;
        store_d       = store_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rd_d          = rd_q;
        cnt_d         = cnt_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        wb_en_d       = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        done_d        = 1'b0;
        fault_d       = 1'b0;
        fault_cause_d = FC_NONE;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    store_d  = req_is_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rd_d     = req_rd;
                    state_d  = ST_CHECK;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // Illegal encoding outranks misalignment.
                if (funct3_illegal(store_q, funct3_q)) begin
                    fault_d       = 1'b1;
                    fault_cause_d = FC_ILLEGAL;
                    state_d       = ST_IDLE;
                end else if (addr_misaligned(funct3_q, addr_q[1:0])) begin
                    fault_d       = 1'b1;
                    fault_cause_d = FC_MISALIGN;
                    state_d       = ST_IDLE;
                end else begin
                    mem_we_d    = store_q;
                    mem_addr_d  = {addr_q[31:2], 2'b00};
                    if (store_q) begin
                        mem_wstrb_d = store_strobe(funct3_q, addr_q[1:0]);
                        mem_wdata_d = store_lanes(funct3_q, wdata_q);
                    end else begin
                        mem_wstrb_d = 4'b0000;
                        mem_wdata_d = 32'h0000_0000;
                    end
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    if (store_q) begin
                        done_d  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = 10'd0;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // Data arriving on the timeout cycle still completes the load.
                if (mem_rvalid) begin
                    done_d  = 1'b1;
                    state_d = ST_RESP;
                    if (rd_q != 5'd0) begin
                        wb_en_d   = 1'b1;
                        wb_rd_d   = rd_q;
                        wb_data_d = load_data_s;
                    end else begin
                        wb_en_d   = 1'b0;
                    end
                end else if ((cnt_q + 10'd1) == TIMEOUT_C) begin
                    cnt_d         = 10'd0;
                    fault_d       = 1'b1;
                    fault_cause_d = FC_TIMEOUT;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_RESP: begin
                // Completion pulses are visible during this state.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d     = (state_d == ST_IDLE);
        mem_req_valid_d = (state_d == ST_REQ);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            store_q         <= 1'b0;
            funct3_q        <= 3'b000;
            addr_q          <= 32'h0000_0000;
            wdata_q         <= 32'h0000_0000;
            rd_q            <= 5'd0;
            cnt_q           <= 10'd0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 32'h0000_0000;
            mem_wdata_q     <= 32'h0000_0000;
            mem_wstrb_q     <= 4'b0000;
            wb_en_q         <= 1'b0;
            wb_rd_q         <= 5'd0;
            wb_data_q       <= 32'h0000_0000;
            done_q          <= 1'b0;
            fault_q         <= 1'b0;
            fault_cause_q   <= FC_NONE;
        end else begin
            state_q         <= state_d;
            store_q         <= store_d;
            funct3_q        <= funct3_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rd_q            <= rd_d;
            cnt_q           <= cnt_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wstrb_q     <= mem_wstrb_d;
            wb_en_q         <= wb_en_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            done_q          <= done_d;
            fault_q         <= fault_d;
            fault_cause_q   <= fault_cause_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign wb_en         = wb_en_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign done          = done_q;
    assign fault         = fault_q;
    assign fault_cause   = fault_cause_q;

endmodule

// File: tb/tb_lsu_writeback.sv
// Self-checking bench for lsu_writeback (TIMEOUT overridden to 8).
module tb_lsu_writeback;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;
    logic        fault;
    logic [1:0]  fault_cause;

    lsu_writeback #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .fault(fault), .fault_cause(fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_fault;
        logic [1:0]  cause;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [4:0]  hold_rd;
    logic [31:0] hold_data;
    int          obs_cyc;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_wstrb;
    logic        obs_we;
    logic        hold_ok;
    logic        mreq_seen;

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (lo * 8);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic push_exp(input logic is_fault, input logic [1:0] cause, input logic wb,
                            input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        if (wb) begin
            hold_rd   = rd;
            hold_data = data;
        end
        e.is_fault = is_fault;
        e.cause    = cause;
        e.wb       = wb;
        e.rd       = hold_rd;
        e.data     = hold_data;
        sbq.push_back(e);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        sbq.delete();
        hold_rd = 5'd0;
        hold_data = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one request plus the memory side, then pops the scoreboard on the completion pulse.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] rdata, input int rdy_dly, input int rv_dly);
        int   n;
        int   vcnt;
        int   hs_cyc;
        logic fin;
        exp_t e;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            vectors++; errors++;
            $display("FAIL req_ready_wait: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd; mem_rdata = rdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        obs_cyc = -1; vcnt = 0; hs_cyc = -1; fin = 1'b0; hold_ok = 1'b1; mreq_seen = 1'b0;
        obs_addr = 32'h0; obs_wdata = 32'h0; obs_wstrb = 4'h0; obs_we = 1'b0;
        for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rvalid    = 1'b0;
            if (mem_req_valid) begin
                if (!mreq_seen) begin
                    obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wstrb = mem_wstrb;
                end else if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== {obs_we, obs_addr, obs_wdata, obs_wstrb}) begin
                    hold_ok = 1'b0;
                end
                mreq_seen = 1'b1;
                vcnt++;
                if (vcnt > rdy_dly) begin
                    mem_req_ready = 1'b1;
                    hs_cyc = cyc;
                end
            end
            if (!st && hs_cyc > 0 && rv_dly >= 0 && cyc == hs_cyc + 1 + rv_dly) mem_rvalid = 1'b1;
            if (wb_en || done || fault) begin
                fin = 1'b1;
                obs_cyc = cyc;
                vectors++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: unexpected pulse wb_en=%b done=%b fault=%b", wb_en, done, fault);
                end else begin
                    e = sbq.pop_front();
                    if ({fault, fault_cause, done, wb_en} !== {e.is_fault, e.cause, ~e.is_fault, e.wb}) begin
                        errors++;
                        $display("FAIL completion: fault=%b cause=%b done=%b wb_en=%b required fault=%b cause=%b done=%b wb_en=%b",
                                 fault, fault_cause, done, wb_en, e.is_fault, e.cause, ~e.is_fault, e.wb);
                    end
                    vectors++;
                    if ({wb_rd, wb_data} !== {e.rd, e.data}) begin
                        errors++;
                        $display("FAIL wb_fields: wb_rd=%0d wb_data=%h required wb_rd=%0d wb_data=%h", wb_rd, wb_data, e.rd, e.data);
                    end
                end
            end
        end
        if (!fin) begin
            vectors++; errors++;
            $display("FAIL completion_timeout: no done/fault within 60 cycles, required one");
            if (sbq.size() > 0) e = sbq.pop_front();
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        vectors++;
        if ({wb_en, done, fault} !== 3'b000) begin
            errors++;
            $display("FAIL pulse_width: wb_en/done/fault=%b required 000", {wb_en, done, fault});
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({req_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_en, wb_rd, wb_data, done, fault, fault_cause}
            !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_state: req_ready=%b mem_req_valid=%b wb_en=%b done=%b fault=%b required 1 0 0 0 0",
                     req_ready, mem_req_valid, wb_en, done, fault);
        end
        // Stale read responses while idle must be ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({req_ready, wb_en, done, fault} !== 4'b1000) begin
                errors++;
                $display("FAIL stale_rvalid: ready/wb/done/fault=%b required 1000", {req_ready, wb_en, done, fault});
            end
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_load_byte();
        push_exp(1'b0, 2'b00, 1'b1, 5'd5, 32'hFFFF_FF80);
        run_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5, 32'h80FF_1234, 0, 0);
        vectors++;
        if ({obs_addr, obs_wstrb, obs_we, obs_cyc} !== {32'h0000_1000, 4'b0000, 1'b0, 32'd4}) begin
            errors++;
            $display("FAIL lb_request: addr=%h wstrb=%b we=%b cyc=%0d required 00001000 0000 0 4", obs_addr, obs_wstrb, obs_we, obs_cyc);
        end
        push_exp(1'b0, 2'b00, 1'b1, 5'd6, 32'h0000_0012);
        run_op(1'b0, 3'b100, 32'h0000_1001, 32'h0, 5'd6, 32'h80FF_1234, 0, 0);
    endtask

    task automatic test_load_half();
        push_exp(1'b0, 2'b00, 1'b1, 5'd9, 32'h0000_BEEF);
        run_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd9, 32'hBEEF_0000, 0, 0);
        push_exp(1'b0, 2'b00, 1'b1, 5'd10, 32'hFFFF_BEEF);
        run_op(1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd10, 32'hBEEF_0000, 0, 0);
        vectors++;
        if (obs_addr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL lh_addr: addr=%h required 00002000", obs_addr);
        end
    endtask

    task automatic test_store();
        push_exp(1'b0, 2'b00, 1'b0, 5'd0, 32'h0);
        run_op(1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 5'd3, 32'h0, 3, -1);
        vectors++;
        if ({obs_we, obs_addr, obs_wstrb, obs_wdata, hold_ok, obs_cyc} !== {1'b1, 32'h0000_3000, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'd6}) begin
            errors++;
            $display("FAIL sh_request: we=%b addr=%h wstrb=%b wdata=%h held=%b cyc=%0d required 1 00003000 1100 abcdabcd 1 6",
                     obs_we, obs_addr, obs_wstrb, obs_wdata, hold_ok, obs_cyc);
        end
        push_exp(1'b0, 2'b00, 1'b0, 5'd0, 32'h0);
        run_op(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00EF, 5'd3, 32'h0, 0, -1);
        vectors++;
        if ({obs_wstrb, obs_wdata, obs_cyc} !== {4'b0010, 32'hEFEF_EFEF, 32'd3}) begin
            errors++;
            $display("FAIL sb_request: wstrb=%b wdata=%h cyc=%0d required 0010 efefefef 3", obs_wstrb, obs_wdata, obs_cyc);
        end
        push_exp(1'b0, 2'b00, 1'b0, 5'd0, 32'h0);
        run_op(1'b1, 3'b010, 32'h0000_3004, 32'hDEAD_BEEF, 5'd3, 32'h0, 1, -1);
        vectors++;
        if ({obs_addr, obs_wstrb, obs_wdata} !== {32'h0000_3004, 4'b1111, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL sw_request: addr=%h wstrb=%b wdata=%h required 00003004 1111 deadbeef", obs_addr, obs_wstrb, obs_wdata);
        end
    endtask

    task automatic test_faults();
        logic        st_t[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3_t[5]  = '{3'b010, 3'b011, 3'b100, 3'b001, 3'b111};
        logic [31:0] ad_t[5]  = '{32'h4001, 32'h4000, 32'h4000, 32'h4003, 32'h4001};
        logic [1:0]  cz_t[5]  = '{2'b01, 2'b11, 2'b11, 2'b01, 2'b11};
        for (int i = 0; i < 5; i++) begin
            push_exp(1'b1, cz_t[i], 1'b0, 5'd0, 32'h0);
            run_op(st_t[i], f3_t[i], ad_t[i], 32'h5555_5555, 5'd4, 32'h1111_1111, 0, 0);
            vectors++;
            if ({mreq_seen, obs_cyc} !== {1'b0, 32'd2}) begin
                errors++;
                $display("FAIL fault_timing[%0d]: mem_req_seen=%b cyc=%0d required 0 2", i, mreq_seen, obs_cyc);
            end
        end
    endtask

    task automatic test_timeout();
        push_exp(1'b1, 2'b10, 1'b0, 5'd0, 32'h0);
        run_op(1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd8, 32'h0, 0, -1);
        vectors++;
        if (obs_cyc !== 3 + TO) begin
            errors++;
            $display("FAIL timeout_cycle: cyc=%0d required %0d", obs_cyc, 3 + TO);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({req_ready, wb_en, done, fault} !== 4'b1000) begin
                errors++;
                $display("FAIL late_rvalid: ready/wb/done/fault=%b required 1000", {req_ready, wb_en, done, fault});
            end
        end
        mem_rvalid = 1'b0;
        // Data on the very cycle the counter would expire wins over the timeout.
        push_exp(1'b0, 2'b00, 1'b1, 5'd11, 32'h1357_9BDF);
        run_op(1'b0, 3'b010, 32'h0000_5004, 32'h0, 5'd11, 32'h1357_9BDF, 0, TO - 1);
        vectors++;
        if (obs_cyc !== 3 + TO) begin
            errors++;
            $display("FAIL rvalid_at_timeout_cycle: cyc=%0d required %0d", obs_cyc, 3 + TO);
        end
    endtask

    task automatic test_rd0();
        push_exp(1'b0, 2'b00, 1'b0, 5'd0, 32'h0);
        run_op(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd0, 32'h2468_ACE0, 0, 1);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3_t[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          rdy;
        int          rv;
        for (int i = 0; i < 10; i++) begin
            f3    = f3_t[$urandom_range(0, 4)];
            addr  = 32'h0000_7000 + 32'($urandom_range(0, 255));
            if (f3[1:0] == 2'b01) addr[0] = 1'b0;
            if (f3 == 3'b010) addr[1:0] = 2'b00;
            rdata = $urandom;
            rd    = 5'($urandom_range(1, 31));
            rdy   = $urandom_range(0, 2);
            rv    = $urandom_range(0, 3);
            push_exp(1'b0, 2'b00, 1'b1, rd, model_load(f3, addr[1:0], rdata));
            run_op(1'b0, f3, addr, 32'h0, rd, rdata, rdy, rv);
            vectors++;
            if (obs_cyc !== 4 + rdy + rv) begin
                errors++;
                $display("FAIL b2b_latency[%0d]: cyc=%0d required %0d", i, obs_cyc, 4 + rdy + rv);
            end
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h0000_8000; req_rd = 5'd7; mem_req_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, mem_req_valid, wb_en, done, fault} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_mid: ready/mreq/wb/done/fault=%b required 10000", {req_ready, mem_req_valid, wb_en, done, fault});
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_req_ready = 1'b0;
        mem_rvalid = 1'b1;
        hold_rd = 5'd0;
        hold_data = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) mem_rvalid = 1'b0;
            vectors++;
            if ({req_ready, wb_en, done, fault} !== 4'b1000) begin
                errors++;
                $display("FAIL after_reset_mid[%0d]: ready/wb/done/fault=%b required 1000", i, {req_ready, wb_en, done, fault});
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store();
        test_faults();
        test_timeout();
        test_rd0();
        test_back_to_back();
        test_reset_mid();
        vectors++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
